sqrt_res_packer: RTL and testbench
==================================

// Module: sqrt_res_packer
//
// PURPOSE
// - Downstream consumer of the single-cycle sqrt stage: takes its res_vld/res stream, packs PACK
//   consecutive results into one wide word and buffers words in a small FIFO with a
//   valid/ready output.
// - Sqrt stage has no backpressure, so this block absorbs bursts and drops only on FIFO
//   overflow, which it flags sticky.
//
// PARAMETERS
// - RES_WIDTH  4  width of one sqrt result (= DATA_WIDTH/2 of sqrt stage)
// - PACK       2  results per output word, >= 2
// - DEPTH      4  FIFO depth in words, power of two, >= 2
// - local: WORD_W = RES_WIDTH*PACK; PTR_W = clog2(DEPTH); IDX_W = clog2(PACK)
//
// PORTS
// - clk       in   1          clock, all state on rising edge
// - rst       in   1          synchronous reset, active-high
// - in_vld    in   1          sqrt result valid (connects to sqrt res_vld)
// - in_res    in   RES_WIDTH  sqrt result (connects to sqrt res)
// - flush     in   1          emit partially filled word now
// - out_rdy   in   1          downstream accepts head word
// - out_vld   out  1          FIFO non-empty
// - out_data  out  WORD_W     head word; result k of a word in bits [k*RES_WIDTH +: RES_WIDTH]
// - level     out  PTR_W+1    words currently stored, 0..DEPTH
// - overflow  out  1          sticky: a word was dropped on full
// - ovf_clr   in   1          clears overflow
//
// BEHAVIOUR
// - Reset (rst=1 at edge): idx=0, pack buffer=0, FIFO empty, all storage=0, out_vld=0,
//   out_data=0, level=0, overflow=0. Mid-operation reset discards buffered and partial data.
// - Pack: on in_vld, in_res goes to slot idx; idx++. When idx==PACK-1 and in_vld, the word is
//   complete: push it and set idx=0.
// - Flush: when flush=1 and (idx!=0 or in_vld), push the current word with unfilled slots zero,
//   then set idx=0.
//   - flush with idx==0 and in_vld=0: no-op.
//   - flush with in_vld in the same cycle: the result is slotted first, then pushed.
//   - At most one push per cycle.
// - Pop: out_vld & out_rdy at an edge removes the head.
// - Output path: out_data/out_vld are driven directly from FIFO regs (show-ahead), with no
//   comb path from in_* or out_rdy.
// - Latency: completing in_vld at edge N -> out_vld=1 after edge N (visible in cycle N+1).
//   Minimum sqrt-arg-to-word latency is sqrt latency + 1.
// - Full: push with level==DEPTH and no pop -> word dropped, overflow<=1, idx still resets to 0.
//   Push+pop same edge when full -> push accepted, level stays DEPTH.
// - Empty: out_rdy ignored when out_vld=0. Push+pop same edge when empty is not possible
//   (no bypass), so level goes 0->1.
// - level: +1 on push-only, -1 on pop-only, unchanged on both/neither.
// - Pointers wrap modulo DEPTH.
// - overflow: ovf_clr clears it. Drop and ovf_clr in the same cycle -> overflow=1 (set wins).
// - out_data holds its value while out_vld & !out_rdy (stable under backpressure).
//
// STRUCTURE
// - Shared package sqrt_pkg: RES_WIDTH default derivation from DATA_WIDTH, clog2 constant
//   function, WORD_W/PTR_W formulas.
// - One sub-module fifo_sync_rst (#WIDTH, #DEPTH): push/pop/full/empty/level, sync active-high
//   reset, full+pop push allowed.
// - Pack register, idx counter, flush logic and overflow flag live in the top.
//
// TESTING
// - Defaults. Reset, then in_vld with res 3,5 on consecutive cycles -> next cycle out_vld=1,
//   out_data=8'h53, level=1.
// - Res 7 then flush (no in_vld) -> out_data=8'h07. Res 9 with flush in the same cycle ->
//   out_data=8'h09, idx=0.
// - out_rdy=0, 10 results 1..A -> words 21,43,65,87 stored, level=4; 5th word A9 dropped,
//   overflow=1. ovf_clr -> overflow=0.
// - Full FIFO, out_rdy=1 and a completing pair in the same cycle -> word accepted, level stays 4,
//   overflow stays 0, pop order preserved.
// - Random in_vld/out_rdy/flush, 2000 cycles vs. scoreboard -> no loss unless overflow rises;
//   out_data stable while stalled.
// - rst asserted with level=3 and idx=1 -> next cycle out_vld=0, level=0, subsequent pair packs
//   from slot 0.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared constants and helper functions for the sqrt result path.
// Holds the result-width derivation from the sqrt operand width and the
// width formulas used by the packer and its word FIFO.
package sqrt_pkg;

    // Operand width of the upstream sqrt stage. A sqrt result is half as wide.
    localparam int DATA_WIDTH_DEF = 8;

    function automatic int res_width_of(input int data_width);
        return data_width / 2;
    endfunction

    localparam int RES_WIDTH_DEF = res_width_of(DATA_WIDTH_DEF);

    // Ceiling log2 for elaboration-time widths. clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of one packed word holding PACK results.
    function automatic int word_w_of(input int res_width, input int pack);
        return res_width * pack;
    endfunction

    // FIFO pointer width. The level counter is one bit wider so it can hold DEPTH.
    function automatic int ptr_w_of(input int depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_sync_rst.sv
// Synchronous word FIFO with show-ahead head register output.
// A push into a full FIFO is accepted when a pop happens on the same edge.
// A push into an empty FIFO is never forwarded to the output in the same cycle.
module fifo_sync_rst
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_w_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level,
    output logic             drop
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    // Qualify requests: pop only when data is present, push when room exists
    // now or a slot is being freed on this same edge.
    always_comb begin
        w_pop  = pop && !empty;
        w_push = push && (!full || w_pop);
    end

    assign full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign empty = (r_count == '0);
    assign level = r_count;
    assign drop  = push && !w_push;
    // Head word comes straight from storage: no path from push or pop.
    assign rdata = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sqrt_res_packer.sv
// Packs consecutive sqrt results into wide words and buffers them in a FIFO.
// The sqrt stage cannot be stalled, so words are dropped only when the FIFO
// is full and not draining; each drop raises a sticky overflow flag.
module sqrt_res_packer
    import sqrt_pkg::*;
#(
    parameter int RES_WIDTH = RES_WIDTH_DEF,
    parameter int PACK      = 2,
    parameter int DEPTH     = 4,
    localparam int WORD_W   = word_w_of(RES_WIDTH, PACK),
    localparam int PTR_W    = ptr_w_of(DEPTH),
    localparam int IDX_W    = clog2(PACK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [RES_WIDTH-1:0] in_res,
    input  logic                 flush,
    input  logic                 out_rdy,
    output logic                 out_vld,
    output logic [WORD_W-1:0]    out_data,
    output logic [PTR_W:0]       level,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    // Handshake: a word leaves the FIFO on a rising edge where out_vld and
    // out_rdy are both high; out_rdy is ignored while out_vld is low, and
    // out_data holds steady while out_vld is high and out_rdy is low.

    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_pack;
    logic              r_overflow;

    logic [WORD_W-1:0] w_word;
    logic              w_last;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;

    // Word as it stands after this cycle's result is slotted at idx.
    always_comb begin
        w_word = r_pack;
        for (int k = 0; k < PACK; k++) begin
            if (in_vld && (r_idx == IDX_W'(k))) begin
                w_word[k*RES_WIDTH +: RES_WIDTH] = in_res;
            end
        end
    end

    // A word is pushed when its last slot fills, or on flush when it holds
    // at least one result (either already buffered or arriving now).
    always_comb begin
        w_last = in_vld && (r_idx == IDX_W'(PACK - 1));
        w_push = w_last || (flush && (in_vld || (r_idx != '0)));
    end

    // Pack buffer and slot index; the buffer is cleared on every push so
    // unfilled slots of a flushed word read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_pack <= '0;
        end else if (w_push) begin
            r_idx  <= '0;
            r_pack <= '0;
        end else if (in_vld) begin
            r_idx  <= r_idx + 1'b1;
            r_pack <= w_word;
        end
    end

    // Sticky overflow: a drop on the same edge as a clear leaves it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    fifo_sync_rst #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_word),
        .pop   (out_rdy),
        .rdata (out_data),
        .full  (w_full),
        .empty (w_empty),
        .level (level),
        .drop  (w_drop)
    );

    assign out_vld  = !w_empty;
    assign overflow = r_overflow;

    // Full status is implied by level; kept as a named net for probing.
    logic w_unused_full;
    assign w_unused_full = w_full;

endmodule

// File: tb/tb_sqrt_res_packer.sv
// Bench for sqrt_res_packer: directed scenarios plus random traffic, with a
// queue-based reference of the packing/FIFO rules and a separate monitor.
module tb_sqrt_res_packer;

    localparam int RW     = 4;
    localparam int PACK   = 2;
    localparam int DEPTH  = 4;
    localparam int WORD_W = RW * PACK;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld;
    logic [RW-1:0]     in_res;
    logic              flush;
    logic              out_rdy;
    logic              out_vld;
    logic [WORD_W-1:0] out_data;
    logic [PTR_W:0]    level;
    logic              overflow;
    logic              ovf_clr;

    sqrt_res_packer #(
        .RES_WIDTH (RW),
        .PACK      (PACK),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_res   (in_res),
        .flush    (flush),
        .out_rdy  (out_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [WORD_W-1:0] exp_q[$];   // words accepted into the FIFO, oldest first
    int part[$];                   // results waiting to form a word
    int model_level = 0;
    bit model_ovf   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare visible status against the reference after the last edge.
    task automatic check_state();
        check("out_vld", 32'(out_vld), 32'(model_level != 0));
        check("level", 32'(level), 32'(model_level));
        check("overflow", 32'(overflow), 32'(model_ovf));
    endtask

    task automatic check_head(input string name, input logic [WORD_W-1:0] exp);
        check({name, "_vld"}, 32'(out_vld), 32'd1);
        check({name, "_data"}, 32'(out_data), 32'(exp));
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; applies one cycle of stimulus and
    // advances the reference to the state expected after the next edge.
    task automatic drive(input bit vld, input int res, input bit fl, input bit rdy, input bit clr);
        bit pop;
        bit drop;
        logic [WORD_W-1:0] word;
        check_state();
        in_vld  = vld;
        in_res  = RW'(res);
        flush   = fl;
        out_rdy = rdy;
        ovf_clr = clr;
        pop  = rdy && (model_level > 0);
        drop = 1'b0;
        if (vld) part.push_back(res % 16);
        if ((part.size() == PACK) || (fl && part.size() > 0)) begin
            word = '0;
            for (int k = 0; k < part.size(); k++) begin
                word = word | (WORD_W'(part[k]) << (k * RW));
            end
            part.delete();
            if (model_level == DEPTH && !pop) begin
                drop = 1'b1;
            end else begin
                exp_q.push_back(word);
                model_level++;
            end
        end
        if (pop) model_level--;
        if (drop) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_res  = '0;
        flush   = 1'b0;
        out_rdy = 1'b0;
        ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        part.delete();
        model_level = 0;
        model_ovf   = 1'b0;
    endtask

    // ---------------- monitor ----------------
    // Pops the expected queue for every word the DUT hands over, and checks
    // that a stalled head word does not change.
    bit prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", 32'(out_vld), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'(out_data), 32'hffff_ffff);
                end else begin
                    check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = out_vld && !out_rdy;
            prev_data  = out_data;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);

        // Pair 3,5 -> 8'h53 one cycle after completion.
        drive(1, 3, 0, 0, 0);
        drive(1, 5, 0, 0, 0);
        check_head("pair_53", 8'h53);
        check("pair_level", 32'(level), 32'd1);
        drive(0, 0, 0, 1, 0);

        // Flush of a half word, then flush with a result in the same cycle.
        drive(1, 7, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        check_head("flush_07", 8'h07);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);  // flush with nothing buffered: no word
        drive(1, 9, 1, 0, 0);
        check_head("flush_09", 8'h09);
        drive(0, 0, 0, 1, 0);
        drive(1, 2, 0, 0, 0);  // index must be back at slot 0
        drive(1, 1, 0, 0, 0);
        check_head("after_flush_12", 8'h12);
        drive(0, 0, 0, 1, 0);

        // Fill to full, fifth word dropped, then clear overflow.
        for (int i = 1; i <= 10; i++) drive(1, i, 0, 0, 0);
        check("full_level", 32'(level), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        check_head("full_head_21", 8'h21);
        drive(0, 0, 0, 0, 1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Push and pop on the same edge while full.
        drive(1, 11, 0, 0, 0);
        drive(1, 12, 0, 1, 0);
        check("fullpp_level", 32'(level), 32'd4);
        check("fullpp_overflow", 32'(overflow), 32'd0);
        check_head("fullpp_head_43", 8'h43);
        repeat (5) drive(0, 0, 0, 1, 0);

        // Reset with three words stored and one result pending.
        for (int i = 1; i <= 7; i++) drive(1, i, 0, 0, 0);
        check("prereset_level", 32'(level), 32'd3);
        do_reset();
        check("midrst_out_vld", 32'(out_vld), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        drive(1, 4, 0, 0, 0);
        drive(1, 6, 0, 0, 0);
        check_head("midrst_pair_64", 8'h64);
        drive(0, 0, 0, 1, 0);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0);
        end

        // Drain everything, including any partial word.
        drive(0, 0, 1, 1, 0);
        repeat (8) drive(0, 0, 0, 1, 0);
        check_state();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
